// File: rtl/wb_mem_pipe_pkg.sv
// rtl/wb_mem_pipe_pkg.sv - shared constants and sizing helpers for the pipelined Wishbone memory
package wb_mem_pipe_pkg;

  localparam int BYTE_BITS       = 8;
  localparam int MIN_ACK_LATENCY = 1;
  localparam int MIN_OUTSTANDING = 1;

  // Request bundle is {we, addr, data, sel}.
  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / BYTE_BITS;
  endfunction

endpackage

// File: rtl/wb_req_delay.sv
// rtl/wb_req_delay.sv - fixed-depth valid+payload shift register carrying requests to their ack cycle
module wb_req_delay #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];

  always_comb begin
    valid_d    = '0;
    data_d     = '{default: '0};
    valid_d[0] = i_valid & ~i_flush;
    data_d[0]  = i_data;
    for (int i = 1; i < STAGES; i++) begin
      valid_d[i] = valid_q[i-1] & ~i_flush;
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q[STAGES-1];
  assign o_data  = data_q[STAGES-1];

endmodule

// File: rtl/wb_mem_pipe.sv
// rtl/wb_mem_pipe.sv - pipelined Wishbone B4 slave memory with fixed ack latency and stall injection
module wb_mem_pipe
  import wb_mem_pipe_pkg::*;
#(
  parameter int WB_ADDR_WIDTH   = 6,
  parameter int WB_DATA_WIDTH   = 32,
  parameter int MEM_WORDS       = 1 << WB_ADDR_WIDTH,
  parameter int ACK_LATENCY     = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STALL_PERIOD    = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_wb_cyc,
  input  logic                           i_wb_stb,
  output logic                           o_wb_stall,
  output logic                           o_wb_ack,
  input  logic                           i_wb_we,
  input  logic [WB_ADDR_WIDTH-1:0]       i_wb_addr,
  input  logic [WB_DATA_WIDTH-1:0]       i_wb_data,
  input  logic [WB_DATA_WIDTH/8-1:0]     i_wb_sel,
  output logic [WB_DATA_WIDTH-1:0]       o_wb_data
);

  localparam int SEL_W = WB_DATA_WIDTH / BYTE_BITS;
  localparam int REQ_W = req_width(WB_ADDR_WIDTH, WB_DATA_WIDTH);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int INJ_W = (STALL_PERIOD > 0) ? $clog2(STALL_PERIOD + 1) : 1;
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [OUT_W-1:0]         OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
  localparam logic [INJ_W-1:0]         INJ_LAST   = INJ_W'(STALL_PERIOD);
  localparam logic [WB_ADDR_WIDTH:0]   ADDR_LIMIT = (WB_ADDR_WIDTH + 1)'(MEM_WORDS);

  if (ACK_LATENCY < MIN_ACK_LATENCY) begin : g_bad_latency
    $error("wb_mem_pipe: ACK_LATENCY must be at least 1");
  end
  if (MAX_OUTSTANDING < MIN_OUTSTANDING) begin : g_bad_outstanding
    $error("wb_mem_pipe: MAX_OUTSTANDING must be at least 1");
  end
  if ((WB_DATA_WIDTH % BYTE_BITS) != 0) begin : g_bad_data_width
    $error("wb_mem_pipe: WB_DATA_WIDTH must be a multiple of 8");
  end
  if (MEM_WORDS > (1 << WB_ADDR_WIDTH)) begin : g_bad_mem_words
    $error("wb_mem_pipe: MEM_WORDS exceeds the address space");
  end

  logic                     accept;
  logic                     ack_valid;
  logic [REQ_W-1:0]         req_payload;
  logic [REQ_W-1:0]         ack_payload;
  logic                     ack_we;
  logic [WB_ADDR_WIDTH-1:0] ack_addr;
  logic [WB_DATA_WIDTH-1:0] ack_data;
  logic [SEL_W-1:0]         ack_sel;

  logic [OUT_W-1:0]         outstanding_q;
  logic [OUT_W-1:0]         outstanding_d;
  logic [INJ_W-1:0]         inj_cnt_q;
  logic [INJ_W-1:0]         inj_cnt_d;
  logic                     inject_q;
  logic                     inject_d;

  logic [WB_DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [IDX_W-1:0]         mem_idx;
  logic                     addr_in_range;
  logic                     mem_we;
  logic [WB_DATA_WIDTH-1:0] mem_rdata;
  logic [WB_DATA_WIDTH-1:0] mem_wdata;

  assign o_wb_ack   = i_wb_cyc & ack_valid;
  // An ack in the same cycle frees a slot, so a full pipe can still accept.
  assign o_wb_stall = i_wb_cyc & (((outstanding_q == OUT_MAX) & ~o_wb_ack) | inject_q);
  assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;

  assign req_payload = {i_wb_we, i_wb_addr, i_wb_data, i_wb_sel};

  wb_req_delay #(
    .STAGES (ACK_LATENCY),
    .WIDTH  (REQ_W)
  ) u_req_delay (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (~i_wb_cyc),
    .i_valid (accept),
    .i_data  (req_payload),
    .o_valid (ack_valid),
    .o_data  (ack_payload)
  );

  assign ack_we   = ack_payload[REQ_W-1];
  assign ack_addr = ack_payload[WB_DATA_WIDTH + SEL_W +: WB_ADDR_WIDTH];
  assign ack_data = ack_payload[SEL_W +: WB_DATA_WIDTH];
  assign ack_sel  = ack_payload[0 +: SEL_W];

  always_comb begin
    outstanding_d = outstanding_q;
    inj_cnt_d     = inj_cnt_q;
    inject_d      = 1'b0;
    if (!i_wb_cyc) begin
      outstanding_d = '0;
      inj_cnt_d     = '0;
    end else begin
      if (accept && !o_wb_ack) begin
        outstanding_d = outstanding_q + OUT_W'(1);
      end else if (!accept && o_wb_ack) begin
        outstanding_d = outstanding_q - OUT_W'(1);
      end
      if (accept && (STALL_PERIOD != 0)) begin
        if (inj_cnt_q + INJ_W'(1) == INJ_LAST) begin
          inj_cnt_d = '0;
          inject_d  = 1'b1;
        end else begin
          inj_cnt_d = inj_cnt_q + INJ_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      outstanding_q <= '0;
      inj_cnt_q     <= '0;
      inject_q      <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      inj_cnt_q     <= inj_cnt_d;
      inject_q      <= inject_d;
    end
  end

  assign addr_in_range = {1'b0, ack_addr} < ADDR_LIMIT;
  assign mem_idx       = ack_addr[IDX_W-1:0];
  assign mem_rdata     = mem_q[mem_idx];
  assign mem_we        = o_wb_ack & ack_we & addr_in_range;

  always_comb begin
    mem_wdata = mem_rdata;
    for (int b = 0; b < SEL_W; b++) begin
      if (ack_sel[b]) begin
        mem_wdata[b*BYTE_BITS +: BYTE_BITS] = ack_data[b*BYTE_BITS +: BYTE_BITS];
      end
    end
  end

  // Memory content survives reset; only the ack-cycle write touches it.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

  assign o_wb_data = (o_wb_ack & ~ack_we & addr_in_range) ? mem_rdata : '0;

endmodule
